id_ex_hazard_reg: RTL and testbench

ID/EX pipeline register with integrated load-use hazard detection, bubble insertion and branch flush. It sits between decode and execute. It supplies ex_rs1/ex_rs2 to the two EX-stage forwarding-unit instances, and ex_rd/ex_reg_write to the EX/MEM register. Because the forwarding unit does not special-case x0, this block also guarantees that any write to x0 leaves ID/EX with reg_write=0.

---
 rtl/id_ex_hazard_reg.sv | 121 ++++++++++++
 tb/tb_id_ex_hazard_reg.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_hazard_reg.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion,
// branch flush, memory-stall freeze and a saturating stall-cycle counter.
module id_ex_hazard_reg #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [4:0]        id_rd,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic [XLEN-1:0]   id_rs1_data,
  input  logic [XLEN-1:0]   id_rs2_data,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              ex_branch_taken,
  input  logic              mem_stall,
  output logic              pc_write,
  output logic              if_id_write,
  output logic              if_id_flush,
  output logic              ex_valid,
  output logic [XLEN-1:0]   ex_pc,
  output logic [4:0]        ex_rs1,
  output logic [4:0]        ex_rs2,
  output logic [4:0]        ex_rd,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic [XLEN-1:0]   ex_rs1_data,
  output logic [XLEN-1:0]   ex_rs2_data,
  output logic [XLEN-1:0]   ex_imm,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [CNT_W-1:0]  stall_count
);

  // An all-zero value of this struct is by construction a bubble.
  typedef struct packed {
    logic              valid;
    logic [XLEN-1:0]   pc;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [4:0]        rd;
    logic              reg_write;
    logic              mem_read;
    logic [XLEN-1:0]   rs1_data;
    logic [XLEN-1:0]   rs2_data;
    logic [XLEN-1:0]   imm;
    logic [CTRL_W-1:0] ctrl;
  } id_ex_t;

  id_ex_t             stage_q, stage_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               lu;

  assign lu = stage_q.valid && stage_q.mem_read && (stage_q.rd != 5'd0) && id_valid &&
              ((id_use_rs1 && (id_rs1 == stage_q.rd)) ||
               (id_use_rs2 && (id_rs2 == stage_q.rd)));

  // A taken branch overrides the load-use stall: the dependent instruction is discarded anyway.
  assign pc_write    = !mem_stall && (ex_branch_taken || !lu);
  assign if_id_write = !mem_stall && (ex_branch_taken || !lu);
  assign if_id_flush = !mem_stall && ex_branch_taken;

  always_comb begin
    // NOTE: defaults first so every path assigns every bit; otherwise a latch is inferred.
    stage_d = stage_q;
    cnt_d   = cnt_q;
    if (mem_stall) begin
      stage_d = stage_q;
    end else if (ex_branch_taken) begin
      stage_d = '0;
    end else if (lu) begin
      stage_d = '0;
      cnt_d   = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
    end else begin
      stage_d.valid     = id_valid;
      stage_d.pc        = id_pc;
      stage_d.rs1       = id_rs1;
      stage_d.rs2       = id_rs2;
      stage_d.rd        = id_rd;
      // x0 writes are dropped here so downstream forwarding never matches on x0.
      stage_d.reg_write = id_reg_write && id_valid && (id_rd != 5'd0);
      stage_d.mem_read  = id_mem_read && id_valid;
      stage_d.rs1_data  = id_rs1_data;
      stage_d.rs2_data  = id_rs2_data;
      stage_d.imm       = id_imm;
      stage_d.ctrl      = id_ctrl;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q <= '0;
      cnt_q   <= '0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values regardless of statement order.
      stage_q <= stage_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ex_valid     = stage_q.valid;
  assign ex_pc        = stage_q.pc;
  assign ex_rs1       = stage_q.rs1;
  assign ex_rs2       = stage_q.rs2;
  assign ex_rd        = stage_q.rd;
  assign ex_reg_write = stage_q.reg_write;
  assign ex_mem_read  = stage_q.mem_read;
  assign ex_rs1_data  = stage_q.rs1_data;
  assign ex_rs2_data  = stage_q.rs2_data;
  assign ex_imm       = stage_q.imm;
  assign ex_ctrl      = stage_q.ctrl;
  assign stall_count  = cnt_q;

endmodule

// File: tb/tb_id_ex_hazard_reg.sv
// Directed testbench for id_ex_hazard_reg; a second instance with a 3-bit
// counter shares all inputs so counter saturation is reachable quickly.
module tb_id_ex_hazard_reg;

  localparam int XLEN   = 32;
  localparam int CTRL_W = 8;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              id_valid;
  logic [XLEN-1:0]   id_pc;
  logic [4:0]        id_rs1, id_rs2, id_rd;
  logic              id_use_rs1, id_use_rs2, id_reg_write, id_mem_read;
  logic [XLEN-1:0]   id_rs1_data, id_rs2_data, id_imm;
  logic [CTRL_W-1:0] id_ctrl;
  logic              ex_branch_taken, mem_stall;

  logic              pc_write, if_id_write, if_id_flush;
  logic              ex_valid, ex_reg_write, ex_mem_read;
  logic [XLEN-1:0]   ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]        ex_rs1, ex_rs2, ex_rd;
  logic [CTRL_W-1:0] ex_ctrl;
  logic [CNT_W-1:0]  stall_count;

  logic              s_pc_write, s_if_id_write, s_if_id_flush;
  logic              s_ex_valid, s_ex_reg_write, s_ex_mem_read;
  logic [XLEN-1:0]   s_ex_pc, s_ex_rs1_data, s_ex_rs2_data, s_ex_imm;
  logic [4:0]        s_ex_rs1, s_ex_rs2, s_ex_rd;
  logic [CTRL_W-1:0] s_ex_ctrl;
  logic [2:0]        s_stall_count;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  id_ex_hazard_reg #(.XLEN(XLEN), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_pc(id_pc), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_ctrl(id_ctrl), .ex_branch_taken(ex_branch_taken), .mem_stall(mem_stall),
    .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
    .ex_ctrl(ex_ctrl), .stall_count(stall_count)
  );

  id_ex_hazard_reg #(.XLEN(XLEN), .CTRL_W(CTRL_W), .CNT_W(3)) dut_sat (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_pc(id_pc), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_ctrl(id_ctrl), .ex_branch_taken(ex_branch_taken), .mem_stall(mem_stall),
    .pc_write(s_pc_write), .if_id_write(s_if_id_write), .if_id_flush(s_if_id_flush),
    .ex_valid(s_ex_valid), .ex_pc(s_ex_pc), .ex_rs1(s_ex_rs1), .ex_rs2(s_ex_rs2),
    .ex_rd(s_ex_rd), .ex_reg_write(s_ex_reg_write), .ex_mem_read(s_ex_mem_read),
    .ex_rs1_data(s_ex_rs1_data), .ex_rs2_data(s_ex_rs2_data), .ex_imm(s_ex_imm),
    .ex_ctrl(s_ex_ctrl), .stall_count(s_stall_count)
  );

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [XLEN-1:0] pc,
                        input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic u1, input logic u2, input logic [4:0] rd,
                        input logic rw, input logic mr, input logic [XLEN-1:0] d1,
                        input logic [XLEN-1:0] d2, input logic [XLEN-1:0] imm,
                        input logic [CTRL_W-1:0] ctrl);
    id_valid = v; id_pc = pc; id_rs1 = rs1; id_rs2 = rs2;
    id_use_rs1 = u1; id_use_rs2 = u2; id_rd = rd; id_reg_write = rw;
    id_mem_read = mr; id_rs1_data = d1; id_rs2_data = d2; id_imm = imm; id_ctrl = ctrl;
  endtask

  task automatic set_load_x7(input logic [XLEN-1:0] pc);
    set_id(1'b1, pc, 5'd2, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1, 32'h0, 32'h0, 32'h4, 8'h11);
  endtask

  task automatic set_add_x8_x7(input logic [XLEN-1:0] pc, input logic use1);
    set_id(1'b1, pc, 5'd7, 5'd1, use1, 1'b1, 5'd8, 1'b1, 1'b0,
           32'h1234, 32'h5678, 32'h0, 8'h22);
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic test_reset();
    set_load_x7(32'h100);
    step();
    set_add_x8_x7(32'h104, 1'b1);
    step();
    set_load_x7(32'h108);
    step();
    chk("pre_reset_ex_valid", 64'(ex_valid), 64'd1);
    chk("pre_reset_stall_count", 64'(stall_count), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("reset_ex_valid", 64'(ex_valid), 64'd0);
    chk("reset_ex_pc", 64'(ex_pc), 64'd0);
    chk("reset_ex_rd", 64'(ex_rd), 64'd0);
    chk("reset_ex_mem_read", 64'(ex_mem_read), 64'd0);
    chk("reset_ex_reg_write", 64'(ex_reg_write), 64'd0);
    chk("reset_ex_imm", 64'(ex_imm), 64'd0);
    chk("reset_ex_ctrl", 64'(ex_ctrl), 64'd0);
    chk("reset_stall_count", 64'(stall_count), 64'd0);
    chk("reset_pc_write", 64'(pc_write), 64'd1);
    chk("reset_if_id_write", 64'(if_id_write), 64'd1);
    chk("reset_if_id_flush", 64'(if_id_flush), 64'd0);
    set_id(1'b0, 32'h0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 8'h0);
    #1 rst_n = 1'b1;
    step();
    chk("post_reset_ex_valid", 64'(ex_valid), 64'd0);
  endtask

  task automatic test_pass_through();
    set_id(1'b1, 32'h200, 5'd1, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0,
           32'hAAAA5555, 32'h0F0F0F0F, 32'h10, 8'h5A);
    #1;
    chk("pt_pc_write", 64'(pc_write), 64'd1);
    step();
    chk("pt_ex_valid", 64'(ex_valid), 64'd1);
    chk("pt_ex_rd", 64'(ex_rd), 64'd5);
    chk("pt_ex_reg_write", 64'(ex_reg_write), 64'd1);
    chk("pt_ex_imm", 64'(ex_imm), 64'h10);
    chk("pt_ex_pc", 64'(ex_pc), 64'h200);
    chk("pt_ex_rs1", 64'(ex_rs1), 64'd1);
    chk("pt_ex_rs1_data", 64'(ex_rs1_data), 64'hAAAA5555);
    chk("pt_ex_rs2_data", 64'(ex_rs2_data), 64'h0F0F0F0F);
    chk("pt_ex_ctrl", 64'(ex_ctrl), 64'h5A);
    chk("pt_ex_mem_read", 64'(ex_mem_read), 64'd0);
  endtask

  task automatic test_x0_guard();
    set_id(1'b1, 32'h210, 5'd3, 5'd4, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0,
           32'h1, 32'h2, 32'h0, 8'h0);
    step();
    chk("x0_ex_valid", 64'(ex_valid), 64'd1);
    chk("x0_ex_reg_write", 64'(ex_reg_write), 64'd0);
    set_id(1'b0, 32'h214, 5'd3, 5'd4, 1'b1, 1'b1, 5'd4, 1'b1, 1'b1,
           32'h1, 32'h2, 32'h0, 8'h0);
    step();
    chk("inv_ex_valid", 64'(ex_valid), 64'd0);
    chk("inv_ex_reg_write", 64'(ex_reg_write), 64'd0);
    chk("inv_ex_mem_read", 64'(ex_mem_read), 64'd0);
  endtask

  task automatic test_load_use();
    set_load_x7(32'h300);
    step();
    chk("lu_load_mem_read", 64'(ex_mem_read), 64'd1);
    chk("lu_load_rd", 64'(ex_rd), 64'd7);
    set_add_x8_x7(32'h304, 1'b1);
    #1;
    chk("lu_pc_write", 64'(pc_write), 64'd0);
    chk("lu_if_id_write", 64'(if_id_write), 64'd0);
    chk("lu_if_id_flush", 64'(if_id_flush), 64'd0);
    chk("lu_count_before", 64'(stall_count), 64'd0);
    step();
    chk("lu_count_after", 64'(stall_count), 64'd1);
    chk("lu_bubble_valid", 64'(ex_valid), 64'd0);
    chk("lu_bubble_rd", 64'(ex_rd), 64'd0);
    chk("lu_bubble_pc", 64'(ex_pc), 64'd0);
    chk("lu_release_pc_write", 64'(pc_write), 64'd1);
    step();
    chk("lu_add_valid", 64'(ex_valid), 64'd1);
    chk("lu_add_rs1", 64'(ex_rs1), 64'd7);
    chk("lu_add_rd", 64'(ex_rd), 64'd8);
    chk("lu_add_pc", 64'(ex_pc), 64'h304);
    chk("lu_add_count", 64'(stall_count), 64'd1);
  endtask

  task automatic test_no_hazard();
    set_load_x7(32'h310);
    step();
    set_add_x8_x7(32'h314, 1'b0);
    #1;
    chk("nh_pc_write", 64'(pc_write), 64'd1);
    chk("nh_if_id_write", 64'(if_id_write), 64'd1);
    step();
    chk("nh_ex_valid", 64'(ex_valid), 64'd1);
    chk("nh_ex_pc", 64'(ex_pc), 64'h314);
    chk("nh_count", 64'(stall_count), 64'd1);
  endtask

  task automatic test_flush_beats_stall();
    set_load_x7(32'h320);
    step();
    set_add_x8_x7(32'h324, 1'b1);
    ex_branch_taken = 1'b1;
    #1;
    chk("fl_if_id_flush", 64'(if_id_flush), 64'd1);
    chk("fl_pc_write", 64'(pc_write), 64'd1);
    chk("fl_if_id_write", 64'(if_id_write), 64'd1);
    step();
    chk("fl_bubble_valid", 64'(ex_valid), 64'd0);
    chk("fl_bubble_mem_read", 64'(ex_mem_read), 64'd0);
    chk("fl_count", 64'(stall_count), 64'd1);
    ex_branch_taken = 1'b0;
  endtask

  task automatic test_mem_stall();
    set_load_x7(32'h400);
    step();
    set_add_x8_x7(32'h404, 1'b1);
    ex_branch_taken = 1'b1;
    mem_stall = 1'b1;
    #1;
    chk("ms_pc_write", 64'(pc_write), 64'd0);
    chk("ms_if_id_write", 64'(if_id_write), 64'd0);
    chk("ms_if_id_flush", 64'(if_id_flush), 64'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("ms_hold_valid", 64'(ex_valid), 64'd1);
      chk("ms_hold_pc", 64'(ex_pc), 64'h400);
      chk("ms_hold_rd", 64'(ex_rd), 64'd7);
      chk("ms_hold_mem_read", 64'(ex_mem_read), 64'd1);
      chk("ms_hold_count", 64'(stall_count), 64'd1);
    end
    mem_stall = 1'b0;
    ex_branch_taken = 1'b0;
    step();
    chk("ms_release_count", 64'(stall_count), 64'd2);
    chk("ms_release_bubble", 64'(ex_valid), 64'd0);
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 5; i++) begin
      set_load_x7(32'h500);
      step();
      set_add_x8_x7(32'h504, 1'b1);
      step();
    end
    chk("sat_main_count_mid", 64'(stall_count), 64'd7);
    chk("sat_small_count_mid", 64'(s_stall_count), 64'd7);
    for (int i = 0; i < 3; i++) begin
      set_load_x7(32'h500);
      step();
      set_add_x8_x7(32'h504, 1'b1);
      #1;
      chk("sat_small_stall", 64'(s_pc_write), 64'd0);
      step();
    end
    chk("sat_main_count_end", 64'(stall_count), 64'd10);
    chk("sat_small_count_end", 64'(s_stall_count), 64'd7);
  endtask

  initial begin
    rst_n = 1'b0;
    ex_branch_taken = 1'b0;
    mem_stall = 1'b0;
    set_id(1'b0, 32'h0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 8'h0);
    repeat (2) step();
    rst_n = 1'b1;
    step();
    test_reset();
    test_pass_through();
    test_x0_guard();
    test_load_use();
    test_no_hazard();
    test_flush_beats_stall();
    test_mem_stall();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
